wptr_full: RTL and testbench

Write-side pointer and full-flag block for the asynchronous-comparison FIFO (fifo2). It keeps the binary write address and the Gray write pointer, accepts write requests only while the FIFO is not full, and produces `wfull` from the asynchronous comparator's `afull_n` indication. `wfull` is set immediately and cleared through a two-flop synchronizer. It sits in the write clock domain, opposite the read-pointer/empty logic, and feeds `wptr` to the async comparator and `waddr` to the dual-port memory.

---
 rtl/fifo2_pkg.sv | 15 +
 rtl/full_sync.sv | 25 ++
 rtl/wptr_full.sv | 90 +++++++++
 tb/tb_wptr_full.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fifo2_pkg.sv
// rtl/fifo2_pkg.sv - shared constants and Gray helper for the fifo2 pointer blocks
package fifo2_pkg;

  // Default pointer/address width; FIFO depth is 2**ASIZE_DEF
  localparam int ASIZE_DEF = 4;

  // Default width of the dropped-write counter
  localparam int OVF_W_DEF = 8;

  // Binary to reflected Gray; callers truncate to their pointer width
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return (b >> 1) ^ b;
  endfunction

endpackage

// File: rtl/full_sync.sv
// rtl/full_sync.sv - two-flop full-flag synchronizer with async preset and sync clear
module full_sync (
  input  logic clk,
  input  logic rst,
  input  logic preset_n,
  output logic q
);

  logic q2;

  // Preset to 11 the moment preset_n drops; release walks a 0 through two flops
  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      q  <= 1'b1;
      q2 <= 1'b1;
    end else if (rst) begin
      q  <= 1'b0;
      q2 <= 1'b0;
    end else begin
      q  <= q2;
      q2 <= ~preset_n;
    end
  end

endmodule

// File: rtl/wptr_full.sv
// rtl/wptr_full.sv - fifo2 write pointer and full flag; WPTR_FULL_OVF_CNT_EN adds a dropped-write counter
module wptr_full
  import fifo2_pkg::*;
#(
  parameter int ASIZE = ASIZE_DEF
`ifdef WPTR_FULL_OVF_CNT_EN
  , parameter int OVF_W = OVF_W_DEF
`endif
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             winc,
  input  logic             afull_n,
  input  logic             wovf_clr,
  output logic             wfull,
  output logic             wack,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE-1:0] wptr,
  output logic             wovf
`ifdef WPTR_FULL_OVF_CNT_EN
  , output logic [OVF_W-1:0] wovf_cnt
`endif
);

  logic [ASIZE-1:0] wbin;
  logic [ASIZE-1:0] wgray;
  logic [ASIZE-1:0] wbin_next;
  logic [ASIZE-1:0] wgray_next;
  logic             wrej;

  // A request is accepted only while not full; a request while full is dropped
  assign wack  = winc & ~wfull;
  assign wrej  = winc & wfull;
  assign waddr = wbin;
  assign wptr  = wgray;

  // Next binary and Gray pointers; binary add wraps naturally at 2**ASIZE
  always_comb begin
    wbin_next  = wbin + {{(ASIZE-1){1'b0}}, wack};
    wgray_next = ASIZE'(bin2gray(32'(wbin_next)));
  end

  // Binary and Gray pointers register together so they never disagree
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin  <= '0;
      wgray <= '0;
    end else begin
      wbin  <= wbin_next;
      wgray <= wgray_next;
    end
  end

  // Full flag: set at once by the comparator, cleared after two clean edges
  full_sync u_full_sync (
    .clk      (wclk),
    .rst      (wrst),
    .preset_n (afull_n),
    .q        (wfull)
  );

  // Sticky overflow; a dropped write outranks a clear in the same cycle
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wovf <= 1'b0;
    end else if (wrej) begin
      wovf <= 1'b1;
    end else if (wovf_clr) begin
      wovf <= 1'b0;
    end
  end

`ifdef WPTR_FULL_OVF_CNT_EN
  // Saturating dropped-write count; a drop coinciding with a clear restarts at 1
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wovf_cnt <= '0;
    end else if (wrej) begin
      if (wovf_clr) begin
        wovf_cnt <= {{(OVF_W-1){1'b0}}, 1'b1};
      end else if (wovf_cnt != {OVF_W{1'b1}}) begin
        wovf_cnt <= wovf_cnt + {{(OVF_W-1){1'b0}}, 1'b1};
      end
    end else if (wovf_clr) begin
      wovf_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_wptr_full.sv
// tb/tb_wptr_full.sv - randomized bench for wptr_full against a behavioural model
module tb_wptr_full;

  localparam int ASIZE = 4;
  localparam int DEPTH = 16;
  localparam int CMAX  = 255;

  logic             wclk = 1'b0;
  logic             wrst;
  logic             winc;
  logic             afull_n;
  logic             wovf_clr;
  logic             wfull;
  logic             wack;
  logic [ASIZE-1:0] waddr;
  logic [ASIZE-1:0] wptr;
  logic             wovf;
`ifdef WPTR_FULL_OVF_CNT_EN
  logic [7:0]       wovf_cnt;
`endif

  wptr_full dut (
    .wclk     (wclk),
    .wrst     (wrst),
    .winc     (winc),
    .afull_n  (afull_n),
    .wovf_clr (wovf_clr),
    .wfull    (wfull),
    .wack     (wack),
    .waddr    (waddr),
    .wptr     (wptr),
    .wovf     (wovf)
`ifdef WPTR_FULL_OVF_CNT_EN
    , .wovf_cnt (wovf_cnt)
`endif
  );

  always #5 wclk = ~wclk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: count of accepted writes, sticky flag, drop count, full view
  int m_addr;
  bit m_ovf;
  int m_cnt;
  bit m_full;
  int m_hi;
  logic [3:0] gray_tab [DEPTH] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                   4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input bit i_winc, input bit i_afn, input bit i_clr, input bit i_rst);
    bit rej;
    bit acc;
    #2;
    winc     = i_winc;
    afull_n  = i_afn;
    wovf_clr = i_clr;
    wrst     = i_rst;
    if (!i_afn) begin
      m_full = 1'b1;
      m_hi   = 0;
    end
    #1;
    check("wfull_pre", {31'b0, wfull}, {31'b0, m_full});
    check("wack", {31'b0, wack}, {31'b0, i_winc & ~m_full});
    @(posedge wclk);
    rej = i_winc && m_full;
    acc = i_winc && !m_full;
    if (i_rst) begin
      m_addr = 0;
      m_ovf  = 1'b0;
      m_cnt  = 0;
    end else begin
      if (acc) m_addr = (m_addr + 1) % DEPTH;
      if (rej) m_ovf = 1'b1;
      else if (i_clr) m_ovf = 1'b0;
      if (rej) m_cnt = i_clr ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
      else if (i_clr) m_cnt = 0;
    end
    if (!i_afn) begin
      m_full = 1'b1;
      m_hi   = 0;
    end else if (i_rst) begin
      m_full = 1'b0;
      m_hi   = 2;
    end else begin
      m_hi++;
      if (m_hi >= 2) m_full = 1'b0;
    end
    #1;
    check("waddr", 32'(waddr), 32'(m_addr));
    check("wptr", 32'(wptr), 32'(gray_tab[m_addr]));
    check("wovf", {31'b0, wovf}, {31'b0, m_ovf});
    check("wfull", {31'b0, wfull}, {31'b0, m_full});
`ifdef WPTR_FULL_OVF_CNT_EN
    check("wovf_cnt", 32'(wovf_cnt), 32'(m_cnt));
`endif
  endtask

  initial begin
    wrst = 1'b1; winc = 1'b1; afull_n = 1'b1; wovf_clr = 1'b0;
    @(posedge wclk);
    #1;
    m_addr = 0; m_ovf = 1'b0; m_cnt = 0; m_full = 1'b0; m_hi = 2;
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wptr", 32'(wptr), 32'd0);
    check("rst_wovf", {31'b0, wovf}, 32'd0);
    check("rst_wfull", {31'b0, wfull}, 32'd0);
    check("rst_wack", {31'b0, wack}, 32'd1);

    // Full wrap of the pointer
    for (int i = 0; i < 16; i++) cycle(1, 1, 0, 0);
    check("wrap_waddr", 32'(waddr), 32'd0);

    // Fill to 7, then hit full with a write
    for (int i = 0; i < 7; i++) cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    check("hold_waddr", 32'(waddr), 32'd7);
    check("ovf_set", {31'b0, wovf}, 32'd1);

    // Release: full holds one edge, clears on the second
    cycle(0, 1, 0, 0);
    check("rel_edge1", {31'b0, wfull}, 32'd1);
    cycle(0, 1, 0, 0);
    check("rel_edge2", {31'b0, wfull}, 32'd0);
    cycle(1, 1, 0, 0);

    // Overflow clear, and set beating clear
    cycle(0, 1, 1, 0);
    check("ovf_clr", {31'b0, wovf}, 32'd0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 0);
    check("ovf_set_wins", {31'b0, wovf}, 32'd1);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);

    // Reset mid-operation at waddr 9 with a write pending
    cycle(1, 1, 0, 0);
    check("pre_rst_waddr", 32'(waddr), 32'd9);
    cycle(1, 1, 0, 1);
    check("mid_rst_waddr", 32'(waddr), 32'd0);
    check("mid_rst_wovf", {31'b0, wovf}, 32'd0);
    cycle(0, 0, 0, 1);
    check("rst_preset", {31'b0, wfull}, 32'd1);

    // Many dropped writes saturate the counter, then clear
    for (int i = 0; i < 300; i++) cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) != 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 99) < 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
